phase_ser_load: RTL and testbench

Downstream of the phase-value LUT stage. Collects one registered 5-bit phase word per array element into a local buffer. When the frame is complete, it shifts the whole frame serially into the daisy-chained T/R-module phase-shifter registers, then pulses a latch strobe so all elements update together. It returns to fill mode for the next beam position.

---
 rtl/phvl_pkg.sv | 25 ++
 rtl/ser_tick.sv | 41 ++++
 rtl/phase_ser_load.sv | 161 ++++++++++++++++
 tb/tb_phase_ser_load.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phvl_pkg.sv
// Shared types and constants for the phase-word serial loader.
// Define PHVL_PARITY_EN to append an odd-parity bit to every shifted element.
package phvl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam int PH_W_DEF = 5;

`ifdef PHVL_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int BITS_PER_WORD = PH_W_DEF + PARITY_BITS;

    function automatic int bits_per_word(input int ph_w);
        return ph_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/ser_tick.sv
// Bit-period sequencer: marks the last cycle of each serial bit and drives a
// registered serial clock that is high for the second half of the period.
module ser_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic sclk
);
    localparam int               PH_CW   = $clog2(CLK_DIV);
    localparam logic [PH_CW-1:0] LAST_PH = PH_CW'(CLK_DIV - 1);
    localparam logic [PH_CW-1:0] HALF_PH = PH_CW'(CLK_DIV / 2);

    logic [PH_CW-1:0] phase_q;
    logic [PH_CW-1:0] phase_d;

    // Phase parks at 0 while disabled, so every shift starts on a fresh period.
    always_comb begin
        // NOTE: default first so no path through this block leaves phase_d unassigned (no latch).
        phase_d = '0;
        if (en && phase_q != LAST_PH) begin
            phase_d = phase_q + PH_CW'(1);
        end
    end

    assign tick = en && (phase_q == LAST_PH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            sclk    <= 1'b0;
        end else begin
            // NOTE: non-blocking so both registers sample the pre-edge phase.
            phase_q <= phase_d;
            sclk    <= (phase_d >= HALF_PH);
        end
    end

endmodule

// File: rtl/phase_ser_load.sv
// Buffers one frame of phase words, shifts it into the T/R-module chain and strobes latch.
// Define PHVL_PARITY_EN to append an odd-parity bit after each element's LSB.
module phase_ser_load
    import phvl_pkg::*;
#(
    parameter int N_ELEM  = 16,
    parameter int PH_W    = PH_W_DEF,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ph_valid,
    input  logic [PH_W-1:0] ph_in,
    output logic            ph_ready,
    input  logic            flush,
    output logic            sclk_o,
    output logic            sdata_o,
    output logic            latch_o,
    output logic            busy,
    output logic            done
);
    localparam int BPW    = bits_per_word(PH_W);
    localparam int N_BITS = N_ELEM * BPW;
    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int CNT_W  = $clog2(N_BITS);
    localparam int POS_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LAT_W  = $clog2(CLK_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(BPW - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(CLK_DIV - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] elem_q;
    logic [POS_W-1:0] bpos_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [PH_W-1:0]  frame_mem [N_ELEM];

    logic             accept;
    logic             last_word;
    logic             tick;
    logic             last_bit;
    logic             lat_end;
    logic             shifting;
    logic             last_pos;
    logic [IDX_W-1:0] nxt_elem;
    logic [POS_W-1:0] nxt_pos;
    logic             nxt_bit;

    // Serial order within an element: data MSB..LSB, then the optional parity bit.
    function automatic logic word_bit(input logic [PH_W-1:0] w, input logic [POS_W-1:0] pos);
        logic b;
        b = 1'b0;
        for (int i = 0; i < PH_W; i++) begin
            if (pos == POS_W'(PH_W - 1 - i)) b = w[i];
        end
`ifdef PHVL_PARITY_EN
        if (pos == POS_W'(PH_W)) b = ~^w;
`endif
        return b;
    endfunction

    assign shifting  = (state_q == SHIFT);
    assign accept    = (state_q == FILL) && ph_valid && !flush;
    assign last_word = accept && (wr_idx_q == LAST_IDX);
    assign last_bit  = tick && (bit_cnt_q == LAST_BIT);
    assign lat_end   = (state_q == LATCH) && (lat_cnt_q == LAST_LAT);

    ser_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (shifting),
        .tick(tick),
        .sclk(sclk_o)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (last_word) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = LATCH;
            LATCH:   if (lat_end)   state_d = FILL;
            default:                state_d = FILL;
        endcase
    end

    // Elements leave highest index first, so buf[0] ends nearest the chain input.
    always_comb begin
        last_pos = (bpos_q == LAST_POS);
        nxt_elem = last_pos ? elem_q - IDX_W'(1) : elem_q;
        nxt_pos  = last_pos ? '0 : bpos_q + POS_W'(1);
        nxt_bit  = word_bit(frame_mem[nxt_elem], nxt_pos);
    end

    // NOTE: the frame buffer has no reset; every slot is rewritten before it is shifted.
    always_ff @(posedge clk) begin
        if (accept) frame_mem[wr_idx_q] <= ph_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            wr_idx_q  <= '0;
            elem_q    <= '0;
            bpos_q    <= '0;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            ph_ready  <= 1'b1;
            sdata_o   <= 1'b0;
            latch_o   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_ready <= (state_d == FILL);
            busy     <= (state_d != FILL);
            latch_o  <= (state_d == LATCH);
            done     <= lat_end;

            case (state_q)
                FILL: begin
                    if (flush) begin
                        wr_idx_q <= '0;
                    end else if (accept) begin
                        wr_idx_q <= last_word ? '0 : wr_idx_q + IDX_W'(1);
                    end
                    // The last word is still on ph_in, so its MSB is taken straight from the port.
                    if (last_word) begin
                        elem_q    <= LAST_IDX;
                        bpos_q    <= '0;
                        bit_cnt_q <= '0;
                        sdata_o   <= ph_in[PH_W-1];
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (last_bit) begin
                            sdata_o <= 1'b0;
                        end else begin
                            elem_q    <= nxt_elem;
                            bpos_q    <= nxt_pos;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            sdata_o   <= nxt_bit;
                        end
                    end
                end
                LATCH: begin
                    lat_cnt_q <= lat_end ? '0 : lat_cnt_q + LAT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_ser_load.sv
// Self-checking bench for phase_ser_load: fixed frame table, corner sequences, random frames.
module tb_phase_ser_load;
    import phvl_pkg::*;

    localparam int N_ELEM  = 4;
    localparam int PH_W    = PH_W_DEF;
    localparam int CLK_DIV = 4;
    localparam int BPW     = BITS_PER_WORD;

    typedef struct {
        logic [PH_W-1:0] w [N_ELEM];
        logic [63:0]     bits;
        int              n;
        string           name;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ph_valid = 1'b0;
    logic            flush = 1'b0;
    logic [PH_W-1:0] ph_in = '0;
    logic            ph_ready, sclk_o, sdata_o, latch_o, busy, done;

    int   checks = 0;
    int   errors = 0;
    bit   cap[$];
    vec_t vecs[$];

    phase_ser_load #(
        .N_ELEM (N_ELEM),
        .PH_W   (PH_W),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ph_valid(ph_valid),
        .ph_in   (ph_in),
        .ph_ready(ph_ready),
        .flush   (flush),
        .sclk_o  (sclk_o),
        .sdata_o (sdata_o),
        .latch_o (latch_o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // What the phase-shifter chain sees: data sampled on each serial clock rise.
    always @(posedge sclk_o) cap.push_back(sdata_o);

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Chain contents: last element first, MSB first, then odd parity when configured.
    function automatic void model_stream(input logic [PH_W-1:0] w [N_ELEM],
                                         output logic [63:0] bits, output int n);
        bits = '0;
        n    = 0;
        for (int e = N_ELEM - 1; e >= 0; e--) begin
            for (int b = PH_W - 1; b >= 0; b--) begin
                bits = {bits[62:0], w[e][b]};
                n++;
            end
            if (BPW > PH_W) begin
                bits = {bits[62:0], ($countones(w[e]) % 2 == 0)};
                n++;
            end
        end
    endfunction

    function automatic void add_vec(input logic [PH_W-1:0] a, b, c, d,
                                    input logic [63:0] bits, input int n, input string name);
        vec_t v;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
        v.bits = bits;
        v.n    = n;
        v.name = name;
        vecs.push_back(v);
    endfunction

    // Called at a negedge; returns at the negedge after the word was offered.
    task automatic push(input logic [PH_W-1:0] w);
        int n;
        n = 0;
        while (!ph_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ph_ready) check("push_ready_timeout", ph_ready, 1'b1);
        ph_valid = 1'b1;
        ph_in    = w;
        @(negedge clk);
        ph_valid = 1'b0;
    endtask

    // Called at the negedge of the first SHIFT cycle (right after the last push).
    task automatic observe(input logic [63:0] exp_bits, input int exp_n, input string name);
        int          k, shift_cyc, latch_cyc, done_at;
        bit          bad_ready, bad_latch;
        logic [63:0] act;
        k = 0; shift_cyc = 0; latch_cyc = 0; done_at = -1;
        bad_ready = 1'b0; bad_latch = 1'b0;
        cap.delete();
        while (done_at < 0 && k < 1000) begin
            k++;
            if (busy && !latch_o) shift_cyc++;
            if (latch_o) begin
                latch_cyc++;
                if (sclk_o || sdata_o) bad_latch = 1'b1;
            end
            if (busy && ph_ready) bad_ready = 1'b1;
            if (done) done_at = k;
            else @(negedge clk);
        end
        check({name, "_done_latency"}, done_at, 1 + exp_n * CLK_DIV + CLK_DIV);
        check({name, "_shift_cycles"}, shift_cyc, exp_n * CLK_DIV);
        check({name, "_latch_cycles"}, latch_cyc, CLK_DIV);
        check({name, "_sclk_pulses"}, cap.size(), exp_n);
        act = '0;
        foreach (cap[i]) act = {act[62:0], cap[i]};
        check({name, "_bits"}, act, exp_bits);
        check({name, "_ready_low_when_busy"}, bad_ready, 1'b0);
        check({name, "_latch_serial_quiet"}, bad_latch, 1'b0);
        check({name, "_ready_busy_at_done"}, {ph_ready, busy}, 2'b10);
        @(negedge clk);
        ph_valid = 1'b0;
        check({name, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        logic [PH_W-1:0] wa [N_ELEM];
        logic [PH_W-1:0] q[$];
        logic [63:0]     eb;
        int              en, n0;

`ifdef PHVL_PARITY_EN
        add_vec(5'h01, 5'h00, 5'h1F, 5'h07, 64'b001110_111110_000001_000010, 24, "par_a");
        add_vec(5'h03, 5'h03, 5'h03, 5'h03, 64'b000111_000111_000111_000111, 24, "par_b");
`else
        add_vec(5'h01, 5'h1F, 5'h0A, 5'h15, 64'b10101_01010_11111_00001, 20, "frame_a");
        add_vec(5'h1F, 5'h00, 5'h1F, 5'h00, 64'b00000_11111_00000_11111, 20, "frame_b");
        add_vec(5'h10, 5'h08, 5'h04, 5'h02, 64'b00010_00100_01000_10000, 20, "frame_c");
`endif

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        check("reset_outputs", {ph_ready, sclk_o, sdata_o, latch_o, busy, done}, 6'b100000);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {ph_ready, sclk_o, sdata_o, latch_o, busy, done}, 6'b100000);
        end

        // Table-driven frames.
        foreach (vecs[v]) begin
            for (int i = 0; i < N_ELEM; i++) push(vecs[v].w[i]);
            observe(vecs[v].bits, vecs[v].n, vecs[v].name);
        end

        // Flush discards a partial frame and wins over a simultaneous word.
        push(5'h11);
        push(5'h12);
        flush = 1'b1; ph_valid = 1'b1; ph_in = 5'h1C;
        @(negedge clk);
        flush = 1'b0; ph_valid = 1'b0;
        for (int i = 0; i < N_ELEM; i++) begin
            wa[i] = 5'h03;
            push(5'h03);
        end
`ifdef PHVL_PARITY_EN
        model_stream(wa, eb, en);
`else
        eb = 64'b00011_00011_00011_00011;
        en = 20;
`endif
        observe(eb, en, "flush");

        // A word held valid through SHIFT/LATCH lands as buf[0] of the next frame.
        push(5'h02); push(5'h04); push(5'h06); push(5'h08);
        ph_valid = 1'b1;
        ph_in    = 5'h1E;
        wa = '{5'h02, 5'h04, 5'h06, 5'h08};
        model_stream(wa, eb, en);
        observe(eb, en, "held_busy");
        push(5'h05); push(5'h0C); push(5'h13);
        wa = '{5'h1E, 5'h05, 5'h0C, 5'h13};
        model_stream(wa, eb, en);
        observe(eb, en, "held_next");

        // Reset during bit 9 of a shift aborts the frame.
        cap.delete();
        push(5'h0F); push(5'h10); push(5'h15); push(5'h0A);
        repeat (37) @(negedge clk);
        check("rst_mid_bits_before", cap.size(), 9);
        #1 rst = 1'b0;
        #1 check("rst_mid_outputs", {ph_ready, sclk_o, sdata_o, latch_o, busy, done}, 6'b100000);
        @(negedge clk);
        rst = 1'b1;
        n0 = cap.size();
        repeat (10) @(negedge clk);
        push(5'h07); push(5'h19); push(5'h0D);
        repeat (10) @(negedge clk);
        check("rst_partial_no_sclk", cap.size(), n0);
        check("rst_partial_state", {ph_ready, busy}, 2'b10);
        push(5'h1A);
        wa = '{5'h07, 5'h19, 5'h0D, 5'h1A};
        model_stream(wa, eb, en);
        observe(eb, en, "after_rst");

        // Random frames with random gaps and occasional flushes.
        for (int f = 0; f < 6; f++) begin
            q.delete();
            while (q.size() < N_ELEM) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (q.size() > 0 && $urandom_range(0, 5) == 0) begin
                    flush    = 1'b1;
                    ph_valid = 1'($urandom_range(0, 1));
                    ph_in    = PH_W'($urandom);
                    @(negedge clk);
                    flush    = 1'b0;
                    ph_valid = 1'b0;
                    q.delete();
                end else begin
                    ph_in = PH_W'($urandom);
                    q.push_back(ph_in);
                    push(ph_in);
                end
            end
            for (int i = 0; i < N_ELEM; i++) wa[i] = q[i];
            model_stream(wa, eb, en);
            observe(eb, en, $sformatf("rand%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
